// File: rtl/mem_stream_seq_if.sv
// ---------------------------------------------------------------------------
// mem_stream_seq_if
// Bundles every non-clock signal of the strided Mem stream sequencer.
//   Command : start, mode, base, stride, count   (controller -> sequencer)
//   Status  : busy, done                         (sequencer  -> controller)
//   Mem     : mem_addr, mem_write_data, mem_write_en (out), mem_read_data (in)
//   Load    : out_data, out_valid (out), out_ready (in)
//   Store   : in_data, in_valid (in), in_ready (out)
// Modports:
//   master : the environment (controller, Mem tile and stream peers)
//   slave  : the sequencer itself
// ---------------------------------------------------------------------------
interface mem_stream_seq_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    logic              start;
    logic              mode;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] stride;
    logic [CNT_W-1:0]  count;
    logic              busy;
    logic              done;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_write_en;
    logic [DATA_W-1:0] mem_read_data;

    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (
        output start, mode, base, stride, count,
        output mem_read_data, out_ready, in_data, in_valid,
        input  busy, done, mem_addr, mem_write_data, mem_write_en,
        input  out_data, out_valid, in_ready
    );

    modport slave (
        input  start, mode, base, stride, count,
        input  mem_read_data, out_ready, in_data, in_valid,
        output busy, done, mem_addr, mem_write_data, mem_write_en,
        output out_data, out_valid, in_ready
    );
endinterface

// File: rtl/mem_stream_seq.sv
// ---------------------------------------------------------------------------
// mem_stream_seq
// Drives the Mem tile with a strided address sequence. Load mode streams the
// words read back from Mem out on a valid/ready port; store mode writes a
// valid/ready input stream into Mem.
// Ports:
//   clk   : single clock, all state on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : mem_stream_seq_if.slave (command/status, Mem port, both streams)
// Load path: Mem returns data one cycle after the address is presented. The
// returned word is offered on out_data in that same cycle; if it is not
// accepted it is parked in a 2-entry FIFO. Issue stalls once FIFO contents
// plus the in-flight read reach two, so back-pressure never drops a word.
// ---------------------------------------------------------------------------
module mem_stream_seq #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input logic            clk,
    input logic            rst_n,
    mem_stream_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;

    logic              mode_q;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] stride_q;
    logic [CNT_W-1:0]  remaining;   // elements still to hand over / write
    logic [CNT_W-1:0]  issue_left;  // load reads still to issue
    logic              inflight;    // a read was issued last cycle

    logic [DATA_W-1:0] fifo_mem [2];
    logic              fifo_rd_ptr;
    logic              fifo_wr_ptr;
    logic [1:0]        fifo_occ;

    logic              start_run;
    logic              load_run;
    logic              store_run;
    logic              have_word;
    logic              issue;
    logic              hs;
    logic              wr;
    logic              push;
    logic              pop;

    assign start_run = (state == IDLE) && bus.start && (bus.count != '0);
    assign load_run  = (state == RUN) && !mode_q;
    assign store_run = (state == RUN) && mode_q;

    // A word is available either parked in the FIFO or arriving from Mem now.
    assign have_word = (fifo_occ != 2'd0) || inflight;
    assign issue     = load_run && (issue_left != '0)
                       && ((3'(fifo_occ) + 3'(inflight)) < 3'd2);
    assign hs        = load_run && have_word && bus.out_ready;
    assign wr        = store_run && (remaining != '0) && bus.in_valid;

    // The returning word bypasses the FIFO only when the FIFO is empty and it
    // is accepted in the same cycle; otherwise it is queued behind the head.
    assign pop  = hs && (fifo_occ != 2'd0);
    assign push = inflight && !(hs && (fifo_occ == 2'd0));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every
        // register samples the pre-edge values of its inputs.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: assigning a default first keeps every path through the
        // block fully specified, so no latch is inferred.
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = (bus.count != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if ((hs || wr) && (remaining == CNT_W'(1))) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        bus.busy           = 1'b0;
        bus.done           = 1'b0;
        bus.in_ready       = 1'b0;
        bus.mem_write_en   = 1'b0;
        bus.mem_write_data = '0;
        bus.out_valid      = 1'b0;
        bus.out_data       = '0;
        bus.mem_addr       = addr;
        case (state)
            RUN: begin
                bus.busy = 1'b1;
                if (mode_q) begin
                    bus.in_ready       = (remaining != '0);
                    bus.mem_write_en   = wr;
                    bus.mem_write_data = bus.in_data;
                end else begin
                    bus.out_valid = have_word;
                    if (fifo_occ != 2'd0) begin
                        bus.out_data = fifo_mem[fifo_rd_ptr];
                    end else if (inflight) begin
                        bus.out_data = bus.mem_read_data;
                    end
                end
            end
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Address generator, counters and FIFO control
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q      <= 1'b0;
            addr        <= '0;
            stride_q    <= '0;
            remaining   <= '0;
            issue_left  <= '0;
            inflight    <= 1'b0;
            fifo_rd_ptr <= 1'b0;
            fifo_wr_ptr <= 1'b0;
            fifo_occ    <= 2'd0;
        end else begin
            if (start_run) begin
                mode_q     <= bus.mode;
                stride_q   <= bus.stride;
                addr       <= bus.base;
                remaining  <= bus.count;
                issue_left <= bus.mode ? '0 : bus.count;
            end

            // Wrap-around past 2^ADDR_W is intentional and silent.
            if (issue || wr) begin
                addr <= addr + stride_q;
            end
            if (issue) begin
                issue_left <= issue_left - CNT_W'(1);
            end
            if (hs || wr) begin
                remaining <= remaining - CNT_W'(1);
            end

            inflight <= issue;

            if (push) begin
                fifo_wr_ptr <= ~fifo_wr_ptr;
            end
            if (pop) begin
                fifo_rd_ptr <= ~fifo_rd_ptr;
            end
            case ({push, pop})
                2'b10:   fifo_occ <= fifo_occ + 2'd1;
                2'b01:   fifo_occ <= fifo_occ - 2'd1;
                default: ;
            endcase
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; the occupancy
        // count and pointers are, and out_data is forced to zero whenever
        // nothing valid is held.
        if (push) begin
            fifo_mem[fifo_wr_ptr] <= bus.mem_read_data;
        end
    end

endmodule

// File: tb/tb_mem_stream_seq.sv
// ---------------------------------------------------------------------------
// tb_mem_stream_seq
// Self-checking bench for mem_stream_seq. A synchronous-read Mem model answers
// every address with a hash of that address one cycle later. Expected load
// words, store writes and addresses are computed from base + i*stride.
// ---------------------------------------------------------------------------
module tb_mem_stream_seq;

    logic clk;
    logic rst_n;

    int checks   = 0;
    int failures = 0;

    logic [31:0] st_data [64];

    mem_stream_seq_if #(.DATA_W(32), .ADDR_W(32), .CNT_W(16)) bus ();

    mem_stream_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Mem tile model: read data valid one cycle after the address.
    always @(posedge clk) bus.mem_read_data <= mem_word(bus.mem_addr);

    // ------------------------------------------------------------------
    // Generic load transfer. rmode: 0 ready always, 1 pattern 1,0,0, 2 random.
    // restart_cyc > 0 pulses start at that RUN cycle and in the DONE cycle.
    // ------------------------------------------------------------------
    task automatic run_load(input logic [31:0] base, input logic [31:0] stride,
                            input int n, input int rmode, input int restart_cyc);
        logic [31:0] exp_q[$];
        logic [31:0] last_addr, prev_data, exp_addr;
        int cyc, hs_cnt, adv, done_cyc;
        bit prev_stall, done_seen, rdy;
        for (int i = 0; i < n; i++) exp_q.push_back(mem_word(base + 32'(i) * stride));
        @(negedge clk);
        bus.start = 1'b1; bus.mode = 1'b0; bus.base = base; bus.stride = stride;
        bus.count = 16'(n); bus.out_ready = 1'b0;
        @(negedge clk);
        bus.start = 1'b0; bus.base = $urandom; bus.stride = $urandom;
        bus.count = 16'($urandom); bus.mode = 1'($urandom);
        cyc = 1; hs_cnt = 0; adv = 0; done_cyc = 0;
        prev_stall = 1'b0; done_seen = 1'b0; last_addr = base; prev_data = '0;
        while (!done_seen && cyc < 300) begin
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = ((cyc - 1) % 3 == 0);
                default: rdy = 1'($urandom);
            endcase
            bus.out_ready = rdy;
            bus.start = (cyc == restart_cyc);
            #1;
            if (bus.done) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
            end else begin
                checks++;
                if (bus.busy !== 1'b1) begin
                    failures++; $display("FAIL load_busy: cyc %0d got %b expected 1", cyc, bus.busy);
                end
                if (cyc == 1) begin
                    checks++;
                    if (bus.mem_addr !== base) begin
                        failures++; $display("FAIL load_first_addr: got %h expected %h", bus.mem_addr, base);
                    end
                end else if (bus.mem_addr !== last_addr) begin
                    adv++;
                    exp_addr = base + 32'(adv) * stride;
                    checks++;
                    if (bus.mem_addr !== exp_addr) begin
                        failures++; $display("FAIL load_addr_seq: step %0d got %h expected %h", adv, bus.mem_addr, exp_addr);
                    end
                end
                checks++;
                if (adv - hs_cnt > 2 || adv > n) begin
                    failures++; $display("FAIL load_outstanding: issued %0d handed %0d count %0d (limit 2 outstanding)", adv, hs_cnt, n);
                end
                checks++;
                if (bus.mem_write_en !== 1'b0 || bus.in_ready !== 1'b0) begin
                    failures++; $display("FAIL load_store_side: wen %b in_ready %b expected 0 0", bus.mem_write_en, bus.in_ready);
                end
                if (rmode == 0 && cyc <= n) begin
                    exp_addr = base + 32'(cyc - 1) * stride;
                    checks++;
                    if (bus.mem_addr !== exp_addr) begin
                        failures++; $display("FAIL load_addr_cycle: cyc %0d got %h expected %h", cyc, bus.mem_addr, exp_addr);
                    end
                end
                if (rmode == 0 && cyc >= 2 && cyc <= n + 1) begin
                    checks++;
                    if (bus.out_valid !== 1'b1) begin
                        failures++; $display("FAIL load_throughput: cyc %0d out_valid %b expected 1", cyc, bus.out_valid);
                    end
                end
                if (prev_stall) begin
                    checks++;
                    if (bus.out_valid !== 1'b1 || bus.out_data !== prev_data) begin
                        failures++; $display("FAIL load_stall_stable: valid %b data %h expected 1 %h", bus.out_valid, bus.out_data, prev_data);
                    end
                end
                if (bus.out_valid === 1'b1 && rdy) begin
                    checks++;
                    if (hs_cnt >= n) begin
                        failures++; $display("FAIL load_extra_word: got %h expected no more words", bus.out_data);
                    end else if (bus.out_data !== exp_q[hs_cnt]) begin
                        failures++; $display("FAIL load_data: word %0d got %h expected %h", hs_cnt, bus.out_data, exp_q[hs_cnt]);
                    end
                    hs_cnt++;
                end
                prev_stall = (bus.out_valid === 1'b1) && !rdy;
                prev_data  = bus.out_data;
                last_addr  = bus.mem_addr;
                @(negedge clk);
                cyc++;
            end
        end
        checks++;
        if (!done_seen) begin
            failures++; $display("FAIL load_timeout: no done after %0d cycles, expected done", cyc);
        end else begin
            if (restart_cyc > 0) begin
                bus.start = 1'b1; bus.count = 16'd5;
            end
            checks++;
            if (bus.busy !== 1'b0 || hs_cnt != n) begin
                failures++; $display("FAIL load_done: busy %b words %0d expected 0 %0d", bus.busy, hs_cnt, n);
            end
            if (rmode == 0) begin
                checks++;
                if (done_cyc != n + 2) begin
                    failures++; $display("FAIL load_done_cycle: got %0d expected %0d", done_cyc, n + 2);
                end
            end
            @(negedge clk);
            bus.start = 1'b0;
            #1;
            checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                failures++; $display("FAIL load_back_idle: done %b busy %b expected 0 0", bus.done, bus.busy);
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Generic store transfer from st_data[]. vmode: 0 valid always, 1 random.
    // ------------------------------------------------------------------
    task automatic run_store(input logic [31:0] base, input logic [31:0] stride,
                             input int n, input int vmode);
        logic [31:0] exp_addr;
        int cyc, w, last_wr, done_cyc;
        bit v, done_seen;
        @(negedge clk);
        bus.start = 1'b1; bus.mode = 1'b1; bus.base = base; bus.stride = stride;
        bus.count = 16'(n); bus.in_valid = 1'b0;
        @(negedge clk);
        bus.start = 1'b0; bus.base = $urandom; bus.stride = $urandom;
        bus.count = 16'($urandom); bus.mode = 1'($urandom);
        cyc = 1; w = 0; last_wr = 0; done_cyc = 0; done_seen = 1'b0;
        while (!done_seen && cyc < 300) begin
            v = (vmode == 0) ? 1'b1 : 1'($urandom);
            bus.in_valid = v;
            bus.in_data  = (w < n) ? st_data[w] : $urandom;
            #1;
            if (bus.done) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
                checks++;
                if (bus.mem_write_en !== 1'b0 || bus.in_ready !== 1'b0 || bus.busy !== 1'b0) begin
                    failures++; $display("FAIL store_done_quiet: wen %b in_ready %b busy %b expected 0 0 0",
                                         bus.mem_write_en, bus.in_ready, bus.busy);
                end
            end else begin
                checks++;
                if (bus.busy !== 1'b1 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
                    failures++; $display("FAIL store_run_flags: busy %b in_ready %b out_valid %b expected 1 1 0",
                                         bus.busy, bus.in_ready, bus.out_valid);
                end
                checks++;
                if (bus.mem_write_en !== v) begin
                    failures++; $display("FAIL store_wen: cyc %0d got %b expected %b", cyc, bus.mem_write_en, v);
                end
                if (cyc == 1) begin
                    checks++;
                    if (bus.mem_addr !== base) begin
                        failures++; $display("FAIL store_first_addr: got %h expected %h", bus.mem_addr, base);
                    end
                end
                if (bus.mem_write_en === 1'b1) begin
                    exp_addr = base + 32'(w) * stride;
                    checks++;
                    if (w >= n || bus.mem_addr !== exp_addr || bus.mem_write_data !== st_data[w]) begin
                        failures++; $display("FAIL store_write: #%0d got (%h,%h) expected (%h,%h)",
                                             w, bus.mem_addr, bus.mem_write_data, exp_addr, st_data[w % 64]);
                    end
                    w++;
                    last_wr = cyc;
                end
                @(negedge clk);
                cyc++;
            end
        end
        bus.in_valid = 1'b0;
        checks++;
        if (!done_seen) begin
            failures++; $display("FAIL store_timeout: no done after %0d cycles, expected done", cyc);
        end else begin
            checks++;
            if (w != n || done_cyc != last_wr + 1) begin
                failures++; $display("FAIL store_done: writes %0d done cyc %0d expected %0d %0d", w, done_cyc, n, last_wr + 1);
            end
            @(negedge clk);
            #1;
            checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                failures++; $display("FAIL store_back_idle: done %b busy %b expected 0 0", bus.done, bus.busy);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0; bus.mode = 1'b0; bus.base = '0; bus.stride = '0; bus.count = '0;
        bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_data = 32'hDEAD_BEEF;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.out_valid, bus.in_ready, bus.mem_write_en} !== 5'b0 ||
            bus.mem_addr !== 32'h0 || bus.mem_write_data !== 32'h0 || bus.out_data !== 32'h0) begin
            failures++; $display("FAIL reset_values: flags %b addr %h wdata %h odata %h expected all zero",
                                 {bus.busy, bus.done, bus.out_valid, bus.in_ready, bus.mem_write_en},
                                 bus.mem_addr, bus.mem_write_data, bus.out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_load_basic();
        run_load(32'h0000_0100, 32'd4, 4, 0, 0);
    endtask

    task automatic test_store_basic();
        st_data[0] = 32'hA; st_data[1] = 32'hB; st_data[2] = 32'hC;
        run_store(32'h0000_0020, -32'sd4, 3, 0);
    endtask

    task automatic test_back_pressure();
        run_load(32'h0000_3000, 32'd4, 6, 1, 0);
    endtask

    task automatic test_count_zero();
        for (int m = 0; m < 2; m++) begin
            @(negedge clk);
            bus.start = 1'b1; bus.mode = 1'(m); bus.base = 32'h1234_5678;
            bus.stride = 32'd4; bus.count = 16'd0; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            #1;
            checks++;
            if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.mem_write_en !== 1'b0 ||
                bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
                failures++; $display("FAIL count_zero: mode %0d done %b busy %b wen %b ov %b ir %b expected 1 0 0 0 0",
                                     m, bus.done, bus.busy, bus.mem_write_en, bus.out_valid, bus.in_ready);
            end
            @(negedge clk);
            #1;
            checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                failures++; $display("FAIL count_zero_idle: done %b busy %b expected 0 0", bus.done, bus.busy);
            end
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic test_wrap();
        // Second address is 0xFFFFFFFC + 8 = 0x00000004 after wrap.
        run_load(32'hFFFF_FFFC, 32'd8, 2, 0, 0);
    endtask

    task automatic test_reset_mid_load();
        logic [31:0] w0;
        @(negedge clk);
        bus.start = 1'b1; bus.mode = 1'b0; bus.base = 32'h0000_4000;
        bus.stride = 32'd4; bus.count = 16'd8; bus.out_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            w0 = mem_word(32'h0000_4000 + 32'(k) * 32'd4);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== w0) begin
                failures++; $display("FAIL reset_mid_pre: hs %0d valid %b data %h expected 1 %h", k, bus.out_valid, bus.out_data, w0);
            end
        end
        rst_n = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 32'h5555_AAAA;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.out_valid, bus.in_ready, bus.mem_write_en} !== 5'b0 ||
            bus.mem_addr !== 32'h0 || bus.mem_write_data !== 32'h0 || bus.out_data !== 32'h0) begin
            failures++; $display("FAIL reset_mid_values: flags %b addr %h wdata %h odata %h expected all zero",
                                 {bus.busy, bus.done, bus.out_valid, bus.in_ready, bus.mem_write_en},
                                 bus.mem_addr, bus.mem_write_data, bus.out_data);
        end
        bus.in_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
                failures++; $display("FAIL reset_mid_quiet: done %b busy %b ov %b expected 0 0 0", bus.done, bus.busy, bus.out_valid);
            end
        end
        run_load(32'h0000_5000, 32'd12, 5, 0, 0);
    endtask

    task automatic test_start_ignored();
        run_load(32'h0000_0200, 32'd4, 5, 0, 3);
    endtask

    task automatic test_random();
        logic [31:0] b, s;
        int n;
        for (int t = 0; t < 6; t++) begin
            b = $urandom;
            s = $urandom;
            if (s == 32'h0) s = 32'd4;
            n = $urandom_range(1, 12);
            run_load(b, s, n, 2, 0);
            for (int i = 0; i < n; i++) st_data[i] = $urandom;
            run_store(b ^ 32'h00F0_0000, s, n, 1);
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.mode = 1'b0; bus.base = '0; bus.stride = '0; bus.count = '0;
        bus.out_ready = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
        rst_n = 1'b0;
        test_reset();
        test_load_basic();
        test_store_basic();
        test_back_pressure();
        test_count_zero();
        test_wrap();
        test_reset_mid_load();
        test_start_ignored();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_stream_seq.md
# mem_stream_seq

Stream sequencer sitting directly upstream of the fabric `Mem` tile. It drives `Mem`'s `addr0`/`write_data`/`write_en` with a strided address sequence. In load mode it captures `read_data` into a valid/ready output stream; in store mode it writes a valid/ready input stream into `Mem`. It replaces hand-built address chains made of `const_unit`/`ALU`/`reg_unit` for bulk transfers.

## Interface
- `DATA_W`, 32: data width; must match `Mem` (32).
- `ADDR_W`, 32: address width; must match `Mem` `addr0` (32).
- `CNT_W`, 16: transfer-count width.

- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: begin transfer; sampled only in IDLE.
- `mode` in 1: 0 = load (Mem→stream), 1 = store (stream→Mem); latched at start.
- `base` in ADDR_W: first address; latched at start.
- `stride` in ADDR_W: two's-complement address increment; latched at start.
- `count` in CNT_W: number of elements; latched at start.
- `busy` out 1: transfer in progress.
- `done` out 1: one-cycle completion pulse.
- `mem_addr` out ADDR_W: to `Mem.addr0`.
- `mem_write_data` out DATA_W: to `Mem.write_data`.
- `mem_write_en` out 1: to `Mem.write_en`.
- `mem_read_data` in DATA_W: from `Mem.read_data`; valid exactly 1 cycle after address presented.
- `out_data` out DATA_W, `out_valid` out 1, `out_ready` in 1: load-mode output stream.
- `in_data` in DATA_W, `in_valid` in 1, `in_ready` out 1: store-mode input stream.

## Operation
- States: IDLE, RUN, DONE.
- IDLE→RUN on `start`, when `count`≠0. Latch `mode`, `stride`, `remaining=count`; set `addr=base`.
- IDLE→DONE on `start`, when `count`=0. No memory access.
- RUN→DONE when the last element completes: load = final `out_valid&out_ready`; store = final write.
- DONE→IDLE unconditionally after 1 cycle.
- `busy`=1 in RUN only. `done`=1 in DONE only.
- `start` is ignored outside IDLE.
- Address arithmetic: `addr_next = addr + stride` mod 2^ADDR_W. Wrap-around is silent.
- `mem_addr` = `addr` register; held when no access is issued.
- Load issue:
  - A read issues in a RUN cycle when `issued < count` and `fifo_occ + inflight < 2`.
  - Each issue advances `addr`.
  - The returned word is written into a 2-entry output FIFO on the next cycle.
  - `out_data` comes from the FIFO head and is stable while `out_valid & !out_ready`.
  - Full throughput (1/cycle) is sustained while `out_ready`=1.
  - `out_ready` low for any duration loses no data and issues no extra reads.
- Store:
  - `in_ready` = RUN & `mode` & `remaining`≠0.
  - `mem_write_en` = `in_valid & in_ready`.
  - `mem_write_data` = `in_data` (combinational).
  - Each write advances `addr` and decrements `remaining`.
- In load mode `mem_write_en`=0 and `in_ready`=0. In store mode `out_valid`=0.
- `Mem.reset` is not driven by this block.

## Timing
- Reset values (cycle after `rst_n`=0 sampled):
  - state=IDLE; `busy`, `done`, `out_valid`, `in_ready`, `mem_write_en` = 0.
  - `mem_addr`=0, `mem_write_data`=0, `out_data`=0.
  - FIFO empty, counters 0.
- Reset mid-transfer aborts immediately: FIFO flushed, in-flight read discarded, no `done` pulse.
- `start` sampled at cycle 0:
  - `busy`=1 at cycle 1, `mem_addr`=`base` at cycle 1.
  - Load: first `out_valid` at cycle 2.
  - Store: `in_ready`=1 at cycle 1.
- Load, count=N, `out_ready`=1 throughout: reads at cycles 1..N, handshakes at cycles 2..N+1, `done` at N+2.
- Store, count=N, `in_valid`=1 throughout: writes at cycles 1..N, `done` at N+1.
- `done` and `busy` never both 1. `start` in the DONE cycle is ignored.
- Back-pressure: a read issued while `out_ready`=0 lands in the FIFO. After 2 occupied or in-flight entries, issue stalls.

## Test plan
- Load: base=0x100, stride=4, count=4, `out_ready`=1 -> `mem_addr` 0x100,0x104,0x108,0x10C at cycles 1–4; out words match Mem contents at cycles 2–5; `done` at cycle 6.
- Store: base=0x20, stride=-4, count=3, `in_data` 0xA,0xB,0xC -> writes (0x20,0xA), (0x1C,0xB), (0x18,0xC); `done` 1 cycle after the last write.
- Load back-pressure: count=6, `out_ready` toggling 1,0,0,1,… -> all 6 words in order with no duplicates; `out_data` stable while stalled; never >2 reads outstanding.
- Boundary: count=0 -> `done` at cycle 1, `busy` never 1, no write/read. Also base=0xFFFFFFFC, stride=8, count=2 -> addresses 0xFFFFFFFC then 0x00000004.
- Reset mid-load after 2 handshakes (`rst_n`=0 for 1 cycle) -> all outputs at reset values next cycle, no `done`; a new `start` then runs a clean transfer.
- `start` pulsed during RUN with different base -> ignored; original address sequence completes unchanged.
